// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 timing constants and output helpers for the video pipeline.
package video_timing_pkg;

  // Counters are 10 bits wide, so totals above 1024 are not supported.
  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Map an internal "sync active" flag onto the configured pin polarity.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N up counter with synchronous clear, enable and terminal-count flag.
module wrap_counter #(
  parameter int unsigned Modulus = 800,
  parameter int unsigned Width   = 10
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [Width-1:0] o_count,
  output logic             o_tc
);

  localparam logic [Width-1:0] Last = Width'(Modulus - 1);

  logic [Width-1:0] r_count;
  logic [Width-1:0] w_count_d;

  assign o_tc    = (r_count == Last);
  assign o_count = r_count;

  // Next count: advance when enabled, wrapping to zero after the terminal value.
  always_comb begin
    w_count_d = r_count;
    if (i_en) begin
      w_count_d = o_tc ? '0 : r_count + Width'(1);
    end
  end

  // Count register; clear wins over enable.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters plus registered sync, DE and position outputs.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = video_timing_pkg::VGA_H_ACTIVE,
  parameter int unsigned H_FP     = video_timing_pkg::VGA_H_FP,
  parameter int unsigned H_SYNC   = video_timing_pkg::VGA_H_SYNC,
  parameter int unsigned H_BP     = video_timing_pkg::VGA_H_BP,
  parameter int unsigned V_ACTIVE = video_timing_pkg::VGA_V_ACTIVE,
  parameter int unsigned V_FP     = video_timing_pkg::VGA_V_FP,
  parameter int unsigned V_SYNC   = video_timing_pkg::VGA_V_SYNC,
  parameter int unsigned V_BP     = video_timing_pkg::VGA_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk_25MHz,
  input  logic       resetn,
  input  logic       locked,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  import video_timing_pkg::*;

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HActive    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncFirst = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSyncLast  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VActive    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VSyncFirst = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSyncLast  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic             w_run;
  logic             w_clr;
  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic             w_htc;
  logic             w_vtc_unused;

  // Loss of lock behaves exactly like reset: counters and outputs return to idle.
  assign w_run = resetn & locked;
  assign w_clr = ~w_run;

  wrap_counter #(
    .Modulus(HTotal),
    .Width  (CNT_W)
  ) u_hcnt (
    .i_clk  (clk_25MHz),
    .i_clr  (w_clr),
    .i_en   (1'b1),
    .o_count(w_hcnt),
    .o_tc   (w_htc)
  );

  // Lines advance only on the last pixel of a line.
  wrap_counter #(
    .Modulus(VTotal),
    .Width  (CNT_W)
  ) u_vcnt (
    .i_clk  (clk_25MHz),
    .i_clr  (w_clr),
    .i_en   (w_htc),
    .o_count(w_vcnt),
    .o_tc   (w_vtc_unused)
  );

  logic w_de;
  logic w_hs_act;
  logic w_vs_act;
  logic w_ls;
  logic w_fs;

  // Decode the current counter position into raster events.
  always_comb begin
    w_de     = (w_hcnt < HActive) && (w_vcnt < VActive);
    w_hs_act = (w_hcnt >= HSyncFirst) && (w_hcnt <= HSyncLast);
    w_vs_act = (w_vcnt >= VSyncFirst) && (w_vcnt <= VSyncLast);
    w_ls     = (w_hcnt == '0) && (w_vcnt < VActive);
    w_fs     = (w_hcnt == '0) && (w_vcnt == '0);
  end

  logic       r_hsync;
  logic       r_vsync;
  logic       r_de;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_line_start;
  logic       r_frame_start;

  // Output registers: one cycle behind the counters, idle while reset or unlocked.
  always_ff @(posedge clk_25MHz) begin
    if (!w_run) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= sync_level(w_hs_act, SYNC_POL);
      r_vsync       <= sync_level(w_vs_act, SYNC_POL);
      r_de          <= w_de;
      r_x           <= w_de ? w_hcnt : '0;
      r_y           <= w_de ? w_vcnt : '0;
      r_line_start  <= w_ls;
      r_frame_start <= w_fs;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0, sync polarity where 0 means active-low hsync and vsync.
REQ-010 SHALL have port clk_25MHz, input, 1 bit, the single pixel clock; all logic is on its rising edge.
REQ-011 SHALL have port resetn, input, 1 bit, the reset; it is synchronous and active-low.
REQ-012 SHALL have port locked, input, 1 bit, the PLL lock indication, already in the clk_25MHz domain.
REQ-013 SHALL have port hsync, output, 1 bit, the horizontal sync.
REQ-014 SHALL have port vsync, output, 1 bit, the vertical sync.
REQ-015 SHALL have port de, output, 1 bit, data enable, high during visible pixels.
REQ-016 SHALL have port x, output, 10 bits, the visible pixel column.
REQ-017 SHALL have port y, output, 10 bits, the visible line.
REQ-018 SHALL have port line_start, output, 1 bit, a one-cycle pulse at the first pixel of each line.
REQ-019 SHALL have port frame_start, output, 1 bit, a one-cycle pulse at pixel (0,0) of each frame.

Function
REQ-020 SHALL keep registered counters hcnt, range 0..H_TOTAL-1 with H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800), and vcnt, range 0..V_TOTAL-1 (525).
REQ-021 SHALL increment hcnt every cycle while running, and wrap hcnt from H_TOTAL-1 to 0.
REQ-022 SHALL increment vcnt only in the cycle where hcnt==H_TOTAL-1, and wrap vcnt from V_TOTAL-1 to 0 in that same cycle.
REQ-023 SHALL drive every output from a register, with exactly 1 cycle of latency from the counter state it represents.
REQ-024 SHALL assert de when hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-025 SHALL make x equal to hcnt and y equal to vcnt while de is high, and hold both at 0 while de is low.
REQ-026 SHALL make hsync active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
REQ-027 SHALL make vsync active for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491], spanning whole lines that are aligned to hcnt=0.
REQ-028 SHALL make the active sync level equal to SYNC_POL and the inactive level equal to ~SYNC_POL.
REQ-029 SHALL pulse line_start when hcnt==0 and vcnt<V_ACTIVE.
REQ-030 SHALL pulse frame_start when hcnt==0 and vcnt==0.
REQ-031 SHALL treat locked low as a synchronous hold: counters go to 0 and outputs go to their reset values on the next edge.
REQ-032 SHALL, when locked falls mid-frame, abandon the frame, and on re-lock restart at (0,0) with frame_start.
REQ-033 SHALL, one cycle after the first cycle with resetn=1 and locked=1, output de=1, x=0, y=0, line_start=1 and frame_start=1.
REQ-034 SHALL require parameter sums to fit in 10 bits (H_TOTAL<=1024, V_TOTAL<=1024); no other configuration is supported.

Reset
REQ-035 SHALL, on a rising edge with resetn=0, set hcnt=0, vcnt=0, de=0, x=0, y=0, line_start=0 and frame_start=0.
REQ-036 SHALL, on a rising edge with resetn=0, set hsync and vsync to the inactive level ~SYNC_POL.
REQ-037 SHALL give resetn priority over locked, and let reset asserted mid-frame take effect on the next edge regardless of counter state.

Structure
REQ-038 SHALL place the 640x480@60 timing constants (the eight porch/sync/active defaults and H_TOTAL/V_TOTAL) in shared package video_timing_pkg, for reuse by the HDMI encoder stage.
REQ-039 SHALL use one sub-module, wrap_counter (parameterised modulus, synchronous clear, enable, terminal-count output), instantiated for hcnt and vcnt.

Verification
REQ-040 SHALL verify: reset release with locked=1 -> after 1 cycle frame_start=1, de=1, x=0, y=0; hsync and vsync were 1 during reset.
REQ-041 SHALL verify: run 420000 cycles -> exactly 307200 de-high cycles, 525 hsync pulses of 96 cycles each, 1 vsync pulse of 1600 cycles, 480 line_start pulses and 1 frame_start pulse.
REQ-042 SHALL verify: at line 0 -> hsync asserts 656 cycles after line_start; de falls after x=639; the next line_start comes 800 cycles after the previous one.
REQ-043 SHALL verify: locked dropped at hcnt=300, vcnt=200 for 5 cycles -> outputs are at reset values from the next edge; after re-lock the frame restarts and frame_start comes after 1 cycle.
REQ-044 SHALL verify: SYNC_POL=1 build -> hsync and vsync are idle low and pulse high with the same widths as the default build.
REQ-045 SHALL verify: resetn and locked both low, then resetn released while locked is still low -> no output activity until locked rises.
